// File: rtl/vx_mem_req_limiter.sv
// Memory request limiter: a registered 1-entry request stage that caps the number
// of outstanding reads, with a combinational response pass-through and read-credit accounting.
module vx_mem_req_limiter #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 512,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  in_req_valid,
    input  logic                  in_req_rw,
    input  logic [BE_WIDTH-1:0]   in_req_byteen,
    input  logic [ADDR_WIDTH-1:0] in_req_addr,
    input  logic [DATA_WIDTH-1:0] in_req_data,
    input  logic [TAG_WIDTH-1:0]  in_req_tag,
    output logic                  in_req_ready,

    output logic                  out_req_valid,
    output logic                  out_req_rw,
    output logic [BE_WIDTH-1:0]   out_req_byteen,
    output logic [ADDR_WIDTH-1:0] out_req_addr,
    output logic [DATA_WIDTH-1:0] out_req_data,
    output logic [TAG_WIDTH-1:0]  out_req_tag,
    input  logic                  out_req_ready,

    input  logic                  out_rsp_valid,
    input  logic [DATA_WIDTH-1:0] out_rsp_data,
    input  logic [TAG_WIDTH-1:0]  out_rsp_tag,
    output logic                  out_rsp_ready,

    output logic                  in_rsp_valid,
    output logic [DATA_WIDTH-1:0] in_rsp_data,
    output logic [TAG_WIDTH-1:0]  in_rsp_tag,
    input  logic                  in_rsp_ready,

    output logic [CNT_W-1:0]      pending_reads,
    output logic                  busy,
    output logic                  rsp_underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    // Handshake rule on every channel: a transfer happens on a cycle where valid && ready;
    // once valid is raised the source holds it and its payload stable until that transfer.
    logic             stage_valid;
    logic             stage_free;
    logic             credit_ok;
    logic             fire_in;
    logic             rsp_fire;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             underflow_q;
    logic             underflow_d;

    assign stage_free = !stage_valid || out_req_ready;
    // Credit is judged on the registered count only, so a same-cycle response never frees a slot early.
    assign credit_ok  = (cnt_q != MAX_CNT);
    assign in_req_ready = !reset && stage_free && (in_req_rw || credit_ok);
    assign fire_in    = in_req_valid && in_req_ready;
    assign rsp_fire   = out_rsp_valid && out_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
        end else if (fire_in) begin
            stage_valid <= 1'b1;
        end else if (out_req_ready) begin
            stage_valid <= 1'b0;
        end
    end

    // Payload flops carry no reset; they are only meaningful while stage_valid is set.
    always_ff @(posedge clk) begin
        if (fire_in) begin
            out_req_rw     <= in_req_rw;
            out_req_byteen <= in_req_byteen;
            out_req_addr   <= in_req_addr;
            out_req_data   <= in_req_data;
            out_req_tag    <= in_req_tag;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (rsp_fire && (cnt_q == '0)) begin
            underflow_d = 1'b1;
        end
        if ((fire_in && !in_req_rw) && !rsp_fire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!(fire_in && !in_req_rw) && rsp_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign out_req_valid = stage_valid;
    assign pending_reads = cnt_q;
    assign rsp_underflow = underflow_q;
    assign busy          = (cnt_q != '0) || stage_valid;

    assign in_rsp_valid  = out_rsp_valid;
    assign in_rsp_data   = out_rsp_data;
    assign in_rsp_tag    = out_rsp_tag;
    assign out_rsp_ready = in_rsp_ready;

endmodule

// File: tb/tb_vx_mem_req_limiter.sv
// Directed bench for vx_mem_req_limiter: request ordering/payload via an expected queue,
// plus credit, backpressure, underflow and reset scenarios.
module tb_vx_mem_req_limiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int MP = 4;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MP + 1);
    localparam int PW = 1 + BW + AW + TW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_req_valid = 1'b0;
    logic          in_req_rw = 1'b0;
    logic [BW-1:0] in_req_byteen = '0;
    logic [AW-1:0] in_req_addr = '0;
    logic [DW-1:0] in_req_data = '0;
    logic [TW-1:0] in_req_tag = '0;
    logic          in_req_ready;
    logic          out_req_valid;
    logic          out_req_rw;
    logic [BW-1:0] out_req_byteen;
    logic [AW-1:0] out_req_addr;
    logic [DW-1:0] out_req_data;
    logic [TW-1:0] out_req_tag;
    logic          out_req_ready = 1'b1;
    logic          out_rsp_valid = 1'b0;
    logic [DW-1:0] out_rsp_data = '0;
    logic [TW-1:0] out_rsp_tag = '0;
    logic          out_rsp_ready;
    logic          in_rsp_valid;
    logic [DW-1:0] in_rsp_data;
    logic [TW-1:0] in_rsp_tag;
    logic          in_rsp_ready = 1'b1;
    logic [CW-1:0] pending_reads;
    logic          busy;
    logic          rsp_underflow;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    vx_mem_req_limiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
        .in_req_ready(in_req_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_byteen(out_req_byteen),
        .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
        .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .pending_reads(pending_reads), .busy(busy), .rsp_underflow(rsp_underflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        in_req_valid  = 1'b1;
        in_req_rw     = rw;
        in_req_addr   = addr;
        in_req_tag    = tag;
        in_req_byteen = BW'($urandom_range(1, (1 << BW) - 1));
        in_req_data   = DW'($urandom());
    endtask

    task automatic idle_req();
        in_req_valid = 1'b0;
    endtask

    // scoreboard: push accepted requests, pop and compare on each emitted request
    always @(negedge clk) begin
        if (out_req_valid && out_req_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_req", 64'd1, 64'd0);
            end else begin
                chk("out_req_payload",
                    64'({out_req_rw, out_req_byteen, out_req_addr, out_req_tag, out_req_data}),
                    64'(exp_q.pop_front()));
            end
        end
        if (in_req_valid && in_req_ready) begin
            exp_q.push_back({in_req_rw, in_req_byteen, in_req_addr, in_req_tag, in_req_data});
        end
    end

    initial begin
        // reset, with a read offered that must be refused
        drive_req(1'b0, 16'h0001, 8'h01);
        #1;
        tick();
        chk("ready_in_reset", 64'(in_req_ready), 64'd0);
        idle_req();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", 64'(out_req_valid), 64'd0);
        chk("rst_pending", 64'(pending_reads), 64'd0);
        chk("rst_underflow", 64'(rsp_underflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // single read
        drive_req(1'b0, 16'h0010, 8'h03);
        #1;
        chk("single_ready", 64'(in_req_ready), 64'd1);
        tick();
        idle_req();
        chk("single_out_valid", 64'(out_req_valid), 64'd1);
        chk("single_out_addr", 64'(out_req_addr), 64'h10);
        chk("single_out_tag", 64'(out_req_tag), 64'h3);
        chk("single_pending", 64'(pending_reads), 64'd1);
        tick();
        chk("single_drained", 64'(out_req_valid), 64'd0);
        chk("single_busy_pend", 64'(busy), 64'd1);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = 8'h03;
        out_rsp_data  = 32'hCAFE_0003;
        #1;
        chk("rsp_pass_valid", 64'(in_rsp_valid), 64'd1);
        chk("rsp_pass_tag", 64'(in_rsp_tag), 64'h3);
        chk("rsp_pass_data", 64'(in_rsp_data), 64'hCAFE_0003);
        chk("rsp_pass_ready", 64'(out_rsp_ready), 64'd1);
        tick();
        out_rsp_valid = 1'b0;
        chk("single_pending0", 64'(pending_reads), 64'd0);
        chk("single_busy0", 64'(busy), 64'd0);

        // credit exhaustion
        for (int i = 0; i < MP; i++) begin
            drive_req(1'b0, AW'(16'h0020 + i), TW'(8'h40 + i));
            #1;
            chk("credit_ready", 64'(in_req_ready), 64'd1);
            tick();
        end
        chk("credit_full", 64'(pending_reads), 64'(MP));
        drive_req(1'b0, 16'h0030, 8'h50);
        #1;
        chk("credit_read_blocked", 64'(in_req_ready), 64'd0);
        in_req_rw = 1'b1;
        #1;
        chk("credit_write_ok", 64'(in_req_ready), 64'd1);
        tick();
        drive_req(1'b0, 16'h0031, 8'h51);
        out_rsp_valid = 1'b1;
        #1;
        chk("credit_same_cycle_rsp", 64'(in_req_ready), 64'd0);
        tick();
        out_rsp_valid = 1'b0;
        chk("credit_after_rsp", 64'(pending_reads), 64'(MP - 1));
        #1;
        chk("credit_read_ok", 64'(in_req_ready), 64'd1);
        tick();
        idle_req();
        chk("credit_refull", 64'(pending_reads), 64'(MP));
        out_rsp_valid = 1'b1;
        repeat (MP) tick();
        out_rsp_valid = 1'b0;
        chk("credit_drain", 64'(pending_reads), 64'd0);

        // backpressure
        out_req_ready = 1'b0;
        drive_req(1'b1, 16'h0100, 8'h11);
        #1;
        chk("bp_first_ready", 64'(in_req_ready), 64'd1);
        tick();
        drive_req(1'b0, 16'h0200, 8'h22);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_req_ready), 64'd0);
            chk("bp_out_valid", 64'(out_req_valid), 64'd1);
            chk("bp_out_addr", 64'(out_req_addr), 64'h100);
            chk("bp_out_tag", 64'(out_req_tag), 64'h11);
            tick();
        end
        out_req_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_req_ready), 64'd1);
        tick();
        idle_req();
        chk("bp_second_valid", 64'(out_req_valid), 64'd1);
        chk("bp_second_addr", 64'(out_req_addr), 64'h200);
        tick();
        chk("bp_empty", 64'(out_req_valid), 64'd0);
        out_rsp_valid = 1'b1;
        tick();
        out_rsp_valid = 1'b0;
        chk("bp_pending0", 64'(pending_reads), 64'd0);

        // simultaneous read accept and response
        drive_req(1'b0, 16'h0300, 8'h31);
        tick();
        drive_req(1'b0, 16'h0301, 8'h32);
        tick();
        chk("simul_pre", 64'(pending_reads), 64'd2);
        drive_req(1'b0, 16'h0302, 8'h33);
        out_rsp_valid = 1'b1;
        tick();
        idle_req();
        chk("simul_hold", 64'(pending_reads), 64'd2);
        tick();
        tick();
        out_rsp_valid = 1'b0;
        chk("simul_drain", 64'(pending_reads), 64'd0);

        // underflow
        out_rsp_valid = 1'b1;
        tick();
        out_rsp_valid = 1'b0;
        chk("uf_set", 64'(rsp_underflow), 64'd1);
        chk("uf_no_wrap", 64'(pending_reads), 64'd0);
        tick();
        chk("uf_sticky", 64'(rsp_underflow), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("uf_cleared", 64'(rsp_underflow), 64'd0);

        // reset mid-operation with a staged request
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, AW'(16'h0400 + i), TW'(8'h60 + i));
            tick();
        end
        idle_req();
        tick();
        out_req_ready = 1'b0;
        drive_req(1'b1, 16'h0500, 8'h70);
        tick();
        idle_req();
        chk("mid_pending", 64'(pending_reads), 64'd3);
        chk("mid_staged", 64'(out_req_valid), 64'd1);
        reset = 1'b1;
        out_rsp_valid = 1'b1;
        drive_req(1'b0, 16'h0600, 8'h71);
        exp_q.delete();
        #1;
        chk("mid_ready_in_reset", 64'(in_req_ready), 64'd0);
        tick();
        reset = 1'b0;
        out_rsp_valid = 1'b0;
        idle_req();
        out_req_ready = 1'b1;
        chk("mid_out_valid", 64'(out_req_valid), 64'd0);
        chk("mid_pending0", 64'(pending_reads), 64'd0);
        chk("mid_busy0", 64'(busy), 64'd0);
        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
